// File: rtl/apb_slv_pkg.sv
// Shared definitions for the APB register-bank completer: FSM encoding,
// address-window geometry and the wait-state ceiling.
package apb_slv_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Only the low 12 address bits (one 4 KB window) are decoded.
  localparam int unsigned WIN_BITS = 12;
  // Registers are 32-bit words, so the word index starts at bit 2.
  localparam int unsigned WORD_LSB = 2;
  // Largest wait-state count the 4-bit counter can represent.
  localparam int unsigned WAIT_MAX = 15;

  // True when the address hits an implemented register and is word aligned.
  function automatic logic in_window(input logic [31:0] addr, input int unsigned depth);
    return ({22'd0, addr[WIN_BITS-1:WORD_LSB]} < depth) && (addr[WORD_LSB-1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the bridge (master) and one completer (slave).
interface apb_slave_regbank_if;
  logic        Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slv_regfile.sv
// DEPTH x 32 register array: synchronous write, registered read data,
// every word returns to RESET_VAL on reset.
module apb_slv_regfile #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic          rhit,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Storage: reset every word, otherwise commit completed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register: loaded at setup, zero for writes and misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0000_0000;
    end else if (re) begin
      rdata <= rhit ? mem[raddr] : 32'h0000_0000;
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer for one Pselx lane: IDLE/ACCESS FSM, wait-state counter,
// range decode and a sticky protocol-violation flag in front of a register file.
// Optional build macro APB_SLV_ERR_EN: when defined, out-of-range or misaligned
// accesses complete with Pslverr=1; otherwise Pslverr is tied low.
module apb_slave_regbank
  import apb_slv_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                      Hclk,
  input  logic                      Hresetn,
  apb_slave_regbank_if.slave        bus,
  output logic                      prot_err,
  input  logic                      prot_err_clr
);

  // Out-of-range wait-state settings saturate at the counter ceiling.
  localparam int unsigned WS     = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
  localparam logic [3:0]  WS_END = WS[3:0];
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e      state, state_nxt;
  logic [3:0]  wcnt, wcnt_nxt;
  logic [31:0] addr_l;
  logic        write_l;
  logic        hit_l;
  logic        hit_now;
  logic        setup, ready, abort, mismatch, missing;
  logic        prot_set;
  logic        wr_en;

  assign hit_now = in_window(bus.Paddr, DEPTH);

  // Next-state, counter and event decode from registered state plus bus controls.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    setup     = 1'b0;
    ready     = 1'b0;
    abort     = 1'b0;
    mismatch  = 1'b0;
    missing   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Psel && !bus.Penable) begin
          setup     = 1'b1;
          state_nxt = ACCESS;
          wcnt_nxt  = 4'd0;
        end else if (bus.Psel && bus.Penable) begin
          missing = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (!bus.Psel) begin
          abort     = 1'b1;
          state_nxt = IDLE;
          wcnt_nxt  = 4'd0;
        end else begin
          mismatch = (bus.Paddr != addr_l) || (bus.Pwrite != write_l);
          if (bus.Penable && (wcnt == WS_END)) begin
            ready     = 1'b1;
            state_nxt = IDLE;
            wcnt_nxt  = 4'd0;
          end else if (wcnt != WS_END) begin
            wcnt_nxt = wcnt + 4'd1;
          end else begin
            // Counter parked at the end while Penable is still low.
            wcnt_nxt = wcnt;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = 4'd0;
      end
    endcase
  end

  assign prot_set = missing | mismatch | abort;
  assign wr_en    = ready & write_l & hit_l;

  assign bus.Pready = ready;
`ifdef APB_SLV_ERR_EN
  assign bus.Pslverr = ready & ~hit_l;
`else
  assign bus.Pslverr = 1'b0;
`endif

  // FSM state, wait counter and transfer attributes captured at setup.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      addr_l  <= 32'h0000_0000;
      write_l <= 1'b0;
      hit_l   <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (setup) begin
        addr_l  <= bus.Paddr;
        write_l <= bus.Pwrite;
        hit_l   <= hit_now;
      end
    end
  end

  // Sticky protocol-violation flag; a new violation beats a same-cycle clear.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      prot_err <= 1'b0;
    end else if (prot_set) begin
      prot_err <= 1'b1;
    end else if (prot_err_clr) begin
      prot_err <= 1'b0;
    end
  end

  apb_slv_regfile #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_VAL(RESET_VAL)
  ) u_regfile (
    .clk  (Hclk),
    .rst_n(Hresetn),
    .we   (wr_en),
    .waddr(addr_l[AW+WORD_LSB-1:WORD_LSB]),
    .wdata(bus.Pwdata),
    .re   (setup),
    .rhit (hit_now & ~bus.Pwrite),
    .raddr(bus.Paddr[AW+WORD_LSB-1:WORD_LSB]),
    .rdata(bus.Prdata)
  );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed self-checking bench: three completers (0, 2 and 3 wait states)
// share one driven bus; sel picks which one sees Psel and is observed.
module tb_apb_slave_regbank;

  localparam logic [31:0] RST0 = 32'h5A5A_0001;
`ifdef APB_SLV_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        psel, penable, pwrite, clr;
  logic [31:0] paddr, pwdata;
  int          sel;
  int          cyc;
  int          n_chk;
  int          n_fail;

  logic [31:0] rdata;
  logic        rdy, serr;
  logic        perr0, perr2, perr3;

  apb_slave_regbank_if bus0();
  apb_slave_regbank_if bus2();
  apb_slave_regbank_if bus3();

  assign bus0.Psel = psel && (sel == 0);
  assign bus2.Psel = psel && (sel == 2);
  assign bus3.Psel = psel && (sel == 3);
  assign bus0.Penable = penable;
  assign bus2.Penable = penable;
  assign bus3.Penable = penable;
  assign bus0.Pwrite = pwrite;
  assign bus2.Pwrite = pwrite;
  assign bus3.Pwrite = pwrite;
  assign bus0.Paddr = paddr;
  assign bus2.Paddr = paddr;
  assign bus3.Paddr = paddr;
  assign bus0.Pwdata = pwdata;
  assign bus2.Pwdata = pwdata;
  assign bus3.Pwdata = pwdata;

  assign rdata = (sel == 2) ? bus2.Prdata  : (sel == 3) ? bus3.Prdata  : bus0.Prdata;
  assign rdy   = (sel == 2) ? bus2.Pready  : (sel == 3) ? bus3.Pready  : bus0.Pready;
  assign serr  = (sel == 2) ? bus2.Pslverr : (sel == 3) ? bus3.Pslverr : bus0.Pslverr;

  apb_slave_regbank #(.DEPTH(16), .WAIT_STATES(0), .RESET_VAL(RST0)) u0 (
    .Hclk(clk), .Hresetn(rst_n), .bus(bus0.slave), .prot_err(perr0), .prot_err_clr(clr));
  apb_slave_regbank #(.DEPTH(16), .WAIT_STATES(2), .RESET_VAL(RST0)) u2 (
    .Hclk(clk), .Hresetn(rst_n), .bus(bus2.slave), .prot_err(perr2), .prot_err_clr(clr));
  apb_slave_regbank #(.DEPTH(16), .WAIT_STATES(3)) u3 (
    .Hclk(clk), .Hresetn(rst_n), .bus(bus3.slave), .prot_err(perr3), .prot_err_clr(clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One APB transfer on the selected completer; starts and ends just after a rising edge.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic [31:0] rd_first,
                      output logic err, output int waits, output int done_cyc);
    int guard;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; guard = 0; rd = 32'h0; err = 1'b0; done_cyc = -1;
    @(negedge clk);
    rd_first = rdata;
    while (!rdy && guard < 20) begin
      waits++; guard++;
      @(negedge clk);
    end
    if (rdy) begin
      rd = rdata; err = serr; done_cyc = cyc;
    end else begin
      n_chk++; n_fail++;
      $display("FAIL xfer_timeout: addr %h no Pready within 20 cycles", a);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h want 0", rdata); end
    n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b want 0", rdy); end
    n_chk++; if (serr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr: got %b want 0", serr); end
    n_chk++; if ({perr0, perr2, perr3} !== 3'b000) begin n_fail++; $display("FAIL reset_prot_err: got %b want 000", {perr0, perr2, perr3}); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd, rf; logic err; int w, c;
    sel = 0;
    xfer(1'b1, 32'h008, 32'hDEAD_BEEF, rd, rf, err, w, c);
    n_chk++; if (w !== 0) begin n_fail++; $display("FAIL wr_latency: waits %0d want 0", w); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_slverr: got %b want 0", err); end
    xfer(1'b0, 32'h008, 32'h0, rd, rf, err, w, c);
    n_chk++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_chk++; if (w !== 0) begin n_fail++; $display("FAIL rd_latency: waits %0d want 0", w); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rd_slverr: got %b want 0", err); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, rf; logic err; int w, c;
    sel = 3;
    xfer(1'b1, 32'h004, 32'hCAFE_0004, rd, rf, err, w, c);
    n_chk++; if (w !== 3) begin n_fail++; $display("FAIL ws_wr_waits: got %0d want 3", w); end
    xfer(1'b0, 32'h004, 32'h0, rd, rf, err, w, c);
    n_chk++; if (w !== 3) begin n_fail++; $display("FAIL ws_rd_waits: got %0d want 3", w); end
    n_chk++; if (rd !== 32'hCAFE_0004) begin n_fail++; $display("FAIL ws_rd_data: got %h want cafe0004", rd); end
    n_chk++; if (rf !== 32'hCAFE_0004) begin n_fail++; $display("FAIL ws_rd_early: got %h want cafe0004", rf); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, rf; logic err; int w, c;
    sel = 0;
    xfer(1'b1, 32'h040, 32'h1234_5678, rd, rf, err, w, c);
    n_chk++; if (err !== EXP_ERR) begin n_fail++; $display("FAIL oor_wr_slverr: got %b want %b", err, EXP_ERR); end
    xfer(1'b0, 32'h040, 32'h0, rd, rf, err, w, c);
    n_chk++; if (err !== EXP_ERR) begin n_fail++; $display("FAIL oor_rd_slverr: got %b want %b", err, EXP_ERR); end
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 0", rd); end
    xfer(1'b0, 32'h006, 32'h0, rd, rf, err, w, c);
    n_chk++; if (err !== EXP_ERR) begin n_fail++; $display("FAIL misal_slverr: got %b want %b", err, EXP_ERR); end
    n_chk++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misal_data: got %h want 0", rd); end
    xfer(1'b0, 32'h000, 32'h0, rd, rf, err, w, c);
    n_chk++; if (rd !== RST0) begin n_fail++; $display("FAIL reg0_untouched: got %h want %h", rd, RST0); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reg0_slverr: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, rf; logic err; int w, c1, c2;
    sel = 0;
    xfer(1'b1, 32'h010, 32'h0000_0001, rd, rf, err, w, c1);
    xfer(1'b0, 32'h010, 32'h0, rd, rf, err, w, c2);
    n_chk++; if (c2 - c1 !== 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 2", c2 - c1); end
    n_chk++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL b2b_data: got %h want 1", rd); end
  endtask

  task automatic test_prot_missing_setup();
    sel = 0;
    @(negedge clk);
    n_chk++; if (perr0 !== 1'b0) begin n_fail++; $display("FAIL perr_pre: got %b want 0", perr0); end
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_chk++; if (perr0 !== 1'b1) begin n_fail++; $display("FAIL perr_missing_setup: got %b want 1", perr0); end
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    n_chk++; if (perr0 !== 1'b0) begin n_fail++; $display("FAIL perr_clear: got %b want 0", perr0); end
    @(posedge clk); #1;
  endtask

  task automatic test_prot_addr_change();
    sel = 2;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h008;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    n_chk++; if ({perr2, rdy} !== 2'b00) begin n_fail++; $display("FAIL perr2_acc1: got %b want 00", {perr2, rdy}); end
    @(posedge clk); #1;
    paddr = 32'h00C;
    @(negedge clk);
    n_chk++; if (perr2 !== 1'b0) begin n_fail++; $display("FAIL perr2_acc2: got %b want 0", perr2); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (perr2 !== 1'b1) begin n_fail++; $display("FAIL perr2_addr_change: got %b want 1", perr2); end
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL ws2_ready: got %b want 1", rdy); end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_abort();
    logic [31:0] rd, rf; logic err; int w, c;
    sel = 0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h008; pwdata = 32'h1111_1111;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge clk);
    n_chk++; if ({perr0, rdy} !== 2'b00) begin n_fail++; $display("FAIL abort_acc: got %b want 00", {perr0, rdy}); end
    @(posedge clk); #1;
    penable = 1'b0;
    @(negedge clk);
    n_chk++; if (perr0 !== 1'b1) begin n_fail++; $display("FAIL abort_perr: got %b want 1", perr0); end
    @(posedge clk); #1;
    xfer(1'b0, 32'h008, 32'h0, rd, rf, err, w, c);
    n_chk++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL abort_no_write: got %h want deadbeef", rd); end
    n_chk++; if (w !== 0) begin n_fail++; $display("FAIL abort_idle: waits %0d want 0", w); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, rf; logic err; int w, c;
    sel = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h00C; pwdata = 32'h7777_7777;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ready: got %b want 1", rdy); end
    rst_n = 1'b0;
    #1;
    n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", rdy); end
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_prdata: got %h want 0", rdata); end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h00C, 32'h0, rd, rf, err, w, c);
    n_chk++; if (rd !== RST0) begin n_fail++; $display("FAIL mid_lost_write: got %h want %h", rd, RST0); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; sel = 0;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; clr = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_wait_states();
    test_out_of_range();
    test_back_to_back();
    test_prot_missing_setup();
    test_prot_addr_change();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
